// File: rtl/tile_scheduler.sv
// Splits an M x N x L GEMM into balanced P/Q-bounded tiles; issues one descriptor per tile.
// Planning uses iterative subtraction; each descriptor waits for desc_ready, then for tile_done.
module tile_scheduler #(
   parameter int DIM_W = 8,
   parameter int P     = 8,
   parameter int Q     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_m,
   input  logic [DIM_W-1:0] cfg_n,
   input  logic [DIM_W-1:0] cfg_l,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             desc_valid,
   input  logic             desc_ready,
   output logic [DIM_W-1:0] desc_m_off,
   output logic [DIM_W-1:0] desc_m_size,
   output logic [DIM_W-1:0] desc_n_off,
   output logic [DIM_W-1:0] desc_n_size,
   output logic [DIM_W-1:0] desc_l_off,
   output logic [DIM_W-1:0] desc_l_size,
   output logic             desc_first_k,
   output logic             desc_last_k,
   output logic             desc_last,
   input  logic             tile_done
);
   typedef enum logic [2:0] {S_IDLE, S_PLAN, S_ISSUE, S_WAIT, S_FIN} state_t;

   localparam logic [DIM_W-1:0] LIM_MN = DIM_W'(P);
   localparam logic [DIM_W-1:0] LIM_L  = DIM_W'(Q);

   state_t           r_state, w_next;
   logic [DIM_W-1:0] r_dm, r_dn, r_dl;
   logic [DIM_W-1:0] r_cnt  [3];
   logic [DIM_W-1:0] r_base [3];
   logic [DIM_W-1:0] r_rem  [3];
   logic [DIM_W-1:0] r_acc, r_q;
   logic [1:0]       r_pdim;
   logic             r_pph;
   logic             r_err;
   logic [DIM_W-1:0] r_im, r_in, r_il;
   logic [DIM_W-1:0] r_off_m, r_off_n, r_off_l;

   logic [DIM_W-1:0] w_dim, w_dim_nxt, w_lim, w_cnt_cur;
   logic [DIM_W-1:0] w_sz_m, w_sz_n, w_sz_l;
   logic             w_zero, w_plan_done, w_lk_m, w_lk_n, w_lk_l, w_last;

   always_comb begin
      case (r_pdim)
         2'd0:    w_dim = r_dm;
         2'd1:    w_dim = r_dn;
         default: w_dim = r_dl;
      endcase
      w_dim_nxt = (r_pdim == 2'd0) ? r_dn : r_dl;
      w_lim     = (r_pdim == 2'd2) ? LIM_L : LIM_MN;
   end

   assign w_cnt_cur   = r_cnt[r_pdim];
   assign w_zero      = (r_dm == '0) || (r_dn == '0) || (r_dl == '0);
   assign w_plan_done = r_pph && (r_acc < w_cnt_cur) && (r_pdim == 2'd2);

   // The first `rem` tiles of a dimension carry one extra element.
   assign w_sz_m = r_base[0] + DIM_W'(r_im < r_rem[0]);
   assign w_sz_n = r_base[1] + DIM_W'(r_in < r_rem[1]);
   assign w_sz_l = r_base[2] + DIM_W'(r_il < r_rem[2]);

   assign w_lk_m = (r_im == r_cnt[0] - 1'b1);
   assign w_lk_n = (r_in == r_cnt[1] - 1'b1);
   assign w_lk_l = (r_il == r_cnt[2] - 1'b1);
   assign w_last = w_lk_n && w_lk_l && w_lk_m;

   assign desc_m_off  = r_off_m;
   assign desc_n_off  = r_off_n;
   assign desc_l_off  = r_off_l;
   assign desc_m_size = w_sz_m;
   assign desc_n_size = w_sz_n;
   assign desc_l_size = w_sz_l;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      busy         = (r_state != S_IDLE);
      done         = 1'b0;
      cfg_err      = 1'b0;
      desc_valid   = 1'b0;
      desc_first_k = 1'b0;
      desc_last_k  = 1'b0;
      desc_last    = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_PLAN;
         S_PLAN: begin
            if (w_zero)           w_next = S_FIN;
            else if (w_plan_done) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            desc_valid   = 1'b1;
            desc_first_k = (r_in == '0);
            desc_last_k  = w_lk_n;
            desc_last    = w_last;
            if (desc_ready) w_next = S_WAIT;
         end
         S_WAIT:  if (tile_done) w_next = w_last ? S_FIN : S_ISSUE;
         S_FIN: begin
            done    = 1'b1;
            cfg_err = r_err;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dm    <= '0;  r_dn    <= '0;  r_dl    <= '0;
         r_cnt   <= '{default: '0};
         r_base  <= '{default: '0};
         r_rem   <= '{default: '0};
         r_acc   <= '0;  r_q     <= '0;
         r_pdim  <= '0;  r_pph   <= 1'b0;
         r_err   <= 1'b0;
         r_im    <= '0;  r_in    <= '0;  r_il    <= '0;
         r_off_m <= '0;  r_off_n <= '0;  r_off_l <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_dm    <= cfg_m;  r_dn    <= cfg_n;  r_dl <= cfg_l;
               r_err   <= 1'b0;
               r_pdim  <= '0;     r_pph   <= 1'b0;
               r_acc   <= cfg_m;  r_q     <= DIM_W'(1);
               r_im    <= '0;     r_in    <= '0;     r_il <= '0;
               r_off_m <= '0;     r_off_n <= '0;     r_off_l <= '0;
            end
            S_PLAN: begin
               if (w_zero) begin
                  r_err <= 1'b1;
               end else if (!r_pph) begin
                  // Phase 0: tile count = ceil(D/T)
                  if (r_acc > w_lim) begin
                     r_acc <= r_acc - w_lim;
                     r_q   <= r_q + 1'b1;
                  end else begin
                     r_cnt[r_pdim] <= r_q;
                     r_acc         <= w_dim;
                     r_q           <= '0;
                     r_pph         <= 1'b1;
                  end
               end else begin
                  // Phase 1: base = D/cnt, remainder left in r_acc
                  if (r_acc >= w_cnt_cur) begin
                     r_acc <= r_acc - w_cnt_cur;
                     r_q   <= r_q + 1'b1;
                  end else begin
                     r_base[r_pdim] <= r_q;
                     r_rem[r_pdim]  <= r_acc;
                     if (r_pdim != 2'd2) begin
                        r_pdim <= r_pdim + 1'b1;
                        r_pph  <= 1'b0;
                        r_acc  <= w_dim_nxt;
                        r_q    <= DIM_W'(1);
                     end
                  end
               end
            end
            S_WAIT: if (tile_done && !w_last) begin
               if (!w_lk_n) begin
                  r_in    <= r_in + 1'b1;
                  r_off_n <= r_off_n + w_sz_n;
               end else begin
                  r_in    <= '0;
                  r_off_n <= '0;
                  if (!w_lk_l) begin
                     r_il    <= r_il + 1'b1;
                     r_off_l <= r_off_l + w_sz_l;
                  end else begin
                     r_il    <= '0;
                     r_off_l <= '0;
                     r_im    <= r_im + 1'b1;
                     r_off_m <= r_off_m + w_sz_m;
                  end
               end
            end
            S_FIN:   r_err <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tile_scheduler.sv
// Table of GEMM jobs run against a divide-based reference model through a descriptor scoreboard,
// with stall, noise and mid-job reset sequences folded into the table entries.
module tb_tile_scheduler;
   localparam int DW = 8;
   localparam int TP = 8;
   localparam int TQ = 8;

   typedef struct packed {
      logic [7:0] m_off, m_size, n_off, n_size, l_off, l_size;
      logic       first_k, last_k, last;
   } desc_t;

   typedef struct {
      int m; int n; int l;
      int exp_cnt; bit exp_err;
      int stall; bit noise; int abort;
   } vec_t;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic          desc_ready = 1'b0, tile_done = 1'b0;
   logic [DW-1:0] cfg_m = '0, cfg_n = '0, cfg_l = '0;
   logic          busy, done, cfg_err, desc_valid;
   logic [DW-1:0] desc_m_off, desc_m_size, desc_n_off, desc_n_size, desc_l_off, desc_l_size;
   logic          desc_first_k, desc_last_k, desc_last;

   int    errors = 0, checks = 0, hs_cnt = 0;
   desc_t sb[$];
   desc_t cap[64];

   tile_scheduler #(.DIM_W(DW), .P(TP), .Q(TQ)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_l(cfg_l),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_m_off(desc_m_off), .desc_m_size(desc_m_size),
      .desc_n_off(desc_n_off), .desc_n_size(desc_n_size),
      .desc_l_off(desc_l_off), .desc_l_size(desc_l_size),
      .desc_first_k(desc_first_k), .desc_last_k(desc_last_k), .desc_last(desc_last),
      .tile_done(tile_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && desc_valid && desc_ready) hs_cnt <= hs_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic desc_t mk(int mo, int ms, int no, int ns, int lo, int ls,
                                bit fk, bit lk, bit la);
      desc_t d;
      d.m_off = 8'(mo); d.m_size = 8'(ms);
      d.n_off = 8'(no); d.n_size = 8'(ns);
      d.l_off = 8'(lo); d.l_size = 8'(ls);
      d.first_k = fk; d.last_k = lk; d.last = la;
      return d;
   endfunction

   function automatic desc_t get_cur();
      return mk(int'(desc_m_off), int'(desc_m_size), int'(desc_n_off), int'(desc_n_size),
                int'(desc_l_off), int'(desc_l_size), desc_first_k, desc_last_k, desc_last);
   endfunction

   function automatic int tsz(int d, int c, int i);
      return d / c + ((i < d % c) ? 1 : 0);
   endfunction

   function automatic int toff(int d, int c, int i);
      return i * (d / c) + ((i < d % c) ? i : d % c);
   endfunction

   function automatic void build_expected(int m, int n, int l);
      int cm, cn, cl;
      if (m == 0 || n == 0 || l == 0) return;
      cm = (m + TP - 1) / TP;
      cn = (n + TP - 1) / TP;
      cl = (l + TQ - 1) / TQ;
      for (int im = 0; im < cm; im++)
         for (int il = 0; il < cl; il++)
            for (int in = 0; in < cn; in++)
               sb.push_back(mk(toff(m, cm, im), tsz(m, cm, im), toff(n, cn, in), tsz(n, cn, in),
                               toff(l, cl, il), tsz(l, cl, il), in == 0, in == cn - 1,
                               (in == cn - 1) && (il == cl - 1) && (im == cm - 1)));
   endfunction

   task automatic run_job(input vec_t v);
      desc_t cur, snap, exp_d;
      int    k, t, hs0;
      bit    got_done, aborted;
      build_expected(v.m, v.n, v.l);
      hs0        = hs_cnt;
      desc_ready = 1'b1;
      cfg_m = 8'(v.m); cfg_n = 8'(v.n); cfg_l = 8'(v.l);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      k = 0; got_done = 1'b0; aborted = 1'b0;
      for (int guard = 0; guard < 100; guard++) begin
         t = 0;
         while (!desc_valid && !done && t < 2000) begin
            tick();
            t++;
         end
         if (done) begin
            got_done = 1'b1;
            if (!v.exp_err) chk("done_latency", t, 0);
            break;
         end
         if (!desc_valid) begin
            checks++; errors++;
            $display("FAIL job_timeout: no descriptor or done within %0d cycles", t);
            break;
         end
         if (k > 0) chk("reissue_latency", t, 0);
         cur = get_cur();
         if (v.abort == k) begin
            rst_n = 1'b0;
            #2;
            chk("reset_mid_job", {busy, done, cfg_err, desc_valid, get_cur()}, '0);
            tick();
            rst_n = 1'b1;
            repeat (3) tick();
            chk("no_done_after_abort", {busy, done}, 2'b00);
            sb.delete();
            aborted = 1'b1;
            break;
         end
         if (k == v.stall) begin
            snap = cur;
            repeat (5) begin
               tick();
               chk("stall_hold", {desc_valid, get_cur()}, {1'b1, snap});
            end
            desc_ready = 1'b1;
         end
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_desc: got 0x%0h, expected none", cur);
         end else begin
            exp_d = sb.pop_front();
            chk("desc", cur, exp_d);
         end
         if (k < 64) cap[k] = cur;
         if (v.noise) begin
            tile_done = 1'b1;
            start     = 1'b1;
            cfg_m     = 8'd3;
         end
         tick();
         tile_done = 1'b0;
         start     = 1'b0;
         cfg_m     = 8'(v.m);
         chk("valid_drop", desc_valid, 1'b0);
         tick();
         tick();
         tile_done = 1'b1;
         if (k + 1 == v.stall) desc_ready = 1'b0;
         tick();
         tile_done = 1'b0;
         k++;
      end
      if (got_done && !aborted) begin
         chk("cfg_err", cfg_err, v.exp_err);
         chk("desc_count", k, v.exp_cnt);
         chk("handshakes", hs_cnt - hs0, v.exp_cnt);
         chk("scoreboard_empty", sb.size(), 0);
         sb.delete();
         tick();
         chk("busy_done_clear", {busy, done, cfg_err}, 3'b000);
      end else if (!aborted) begin
         sb.delete();
      end
   endtask

   initial begin
      vec_t vecs[10];
      vecs[0] = '{25, 19, 17, 36, 1'b0,  1, 1'b0, -1};
      vecs[1] = '{ 8,  8,  8,  1, 1'b0, -1, 1'b0, -1};
      vecs[2] = '{25,  0, 17,  0, 1'b1, -1, 1'b0, -1};
      vecs[3] = '{ 9, 16,  1,  4, 1'b0, -1, 1'b1, -1};
      vecs[4] = '{255, 1,  1, 32, 1'b0, -1, 1'b0, -1};
      vecs[5] = '{ 1,  1,  1,  1, 1'b0, -1, 1'b1, -1};
      vecs[6] = '{17,  9, 24, 18, 1'b0,  3, 1'b0, -1};
      vecs[7] = '{ 0,  0,  0,  0, 1'b1, -1, 1'b0, -1};
      vecs[8] = '{25, 19, 17, 36, 1'b0, -1, 1'b0,  9};
      vecs[9] = '{25, 19, 17, 36, 1'b0, -1, 1'b1, -1};

      repeat (3) tick();
      chk("reset_state", {busy, done, cfg_err, desc_valid, get_cur()}, '0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         run_job(vecs[i]);
         if (vecs[i].m == 25 && vecs[i].n == 19 && vecs[i].l == 17 && vecs[i].abort < 0) begin
            chk("desc1", cap[0],  mk( 0, 7,  0, 7,  0, 6, 1'b1, 1'b0, 1'b0));
            chk("desc3", cap[2],  mk( 0, 7, 13, 6,  0, 6, 1'b0, 1'b1, 1'b0));
            chk("desc36", cap[35], mk(19, 6, 13, 6, 12, 5, 1'b0, 1'b1, 1'b1));
         end
         if (vecs[i].m == 8 && vecs[i].n == 8 && vecs[i].l == 8)
            chk("single_desc", cap[0], mk(0, 8, 0, 8, 0, 8, 1'b1, 1'b1, 1'b1));
         repeat (2) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Sequencer that splits a GEMM C(M×L) = A(M×N)·B(N×L) into balanced tiles for the fixed P×Q output-stationary systolic array.
- Emits one tile descriptor at a time over a valid/ready handshake: offsets, sizes, and accumulate/write-back flags.
- Waits for the array datapath to report completion of each tile before issuing the next one.
- Sits between the top-level matrix load/write FSM and the array feeder/readback logic; dimensions are runtime inputs, not elaboration constants.

Parameters:
- DIM_W, 8, width of matrix dimensions, offsets and sizes.
- P, 8, array rows; limits M- and N-direction tile size.
- Q, 8, array columns; limits L-direction tile size.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; latches cfg_* when idle
- cfg_m  in  DIM_W  M dimension
- cfg_n  in  DIM_W  N dimension
- cfg_l  in  DIM_W  L dimension
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of job
- cfg_err  out  1  valid with done; job rejected
- desc_valid  out  1  descriptor valid
- desc_ready  in  1  consumer accepts descriptor
- desc_m_off, desc_m_size  out  DIM_W each  M-tile offset/size
- desc_n_off, desc_n_size  out  DIM_W each  N-tile offset/size
- desc_l_off, desc_l_size  out  DIM_W each  L-tile offset/size
- desc_first_k  out  1  n-tile index 0: array clears accumulators
- desc_last_k  out  1  last n-tile: array results are read back after this tile
- desc_last  out  1  final descriptor of the job
- tile_done  in  1  pulse from datapath: previously accepted tile finished

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-job: abort immediately, no done pulse.
- States: IDLE, PLAN, ISSUE, WAIT, FIN.
- IDLE:
  - start=1 latches cfg_m/n/l, sets busy, goes to PLAN.
  - start while busy is ignored.
- PLAN, per dimension D with limit T (T=P for M and N, T=Q for L):
  - cnt = ceil(D/T); base = D/cnt; rem = D%cnt.
  - Tile i has size base+1 if i<rem, else base; offset of tile i = sum of the preceding sizes.
  - Computed by iterative subtraction, one dimension after another.
  - Latency is data-dependent but at most 3·2^DIM_W cycles; desc_valid stays 0 throughout.
  - Any dimension equal to 0 → FIN with cfg_err=1; no descriptor is issued.
- ISSUE:
  - desc_valid=1; all desc_* fields held stable until desc_valid && desc_ready.
  - On the handshake → WAIT; desc_valid drops the next cycle.
- WAIT:
  - On tile_done: if the accepted descriptor had desc_last → FIN; else advance indices → ISSUE.
  - desc_valid is asserted again the cycle after tile_done.
  - tile_done outside WAIT is ignored.
  - At most one descriptor outstanding.
- Iteration order: m outermost, l middle, n innermost.
  - Advance n; on n wrap, advance l; on l wrap, advance m.
- Incremental offsets: next offset = current offset + current size; reset to 0 on wrap. No multipliers or dividers in the issue path.
- Flags:
  - desc_first_k = (n index == 0).
  - desc_last_k = (n index == cntN−1).
  - desc_last = last_k && last l && last m.
- FIN:
  - done=1 for one cycle; cfg_err is valid that same cycle and cleared afterwards.
  - busy drops with done; returns to IDLE.
  - A start in the FIN cycle is ignored.
- Sizes never exceed P (M, N) or Q (L).
- Sum of sizes in each dimension equals D exactly.
- All arithmetic is unsigned, DIM_W bits; no overflow for D ≤ 2^DIM_W−1.

Test Plan:
- M=25, N=19, L=17, P=Q=8, desc_ready=1, tile_done 3 cycles after each handshake → exactly 36 descriptors.
  - M sizes 7,6,6,6 at offsets 0,7,13,19; N sizes 7,6,6 at 0,7,13; L sizes 6,6,5 at 0,6,12.
  - Descriptor 1 = (0,7 | 0,7 | 0,6), first_k=1.
  - Descriptor 3 = n_off 13, n_size 6, last_k=1.
  - Descriptor 36 = (19,6 | 13,6 | 12,5), last=1; done pulses one cycle after the final tile_done.
- M=N=L=8 → single descriptor (0,8|0,8|0,8) with first_k=last_k=last=1; done after tile_done; cfg_err=0.
- cfg_n=0 → no desc_valid; done=1 with cfg_err=1; busy low next cycle.
- Hold desc_ready=0 for 5 cycles on descriptor 2 → desc_valid and all fields stable; exactly one handshake when ready rises.
- Extra tile_done pulses in ISSUE, and start pulses while busy, → no effect on the descriptor sequence.
- rst_n low during descriptor 10 of the 25/19/17 job → outputs 0 immediately; new start reproduces descriptor 1.
